// File: rtl/ts_pkg.sv
// Shared timestamp definitions for the event capture path, readout and
// register blocks.
package ts_pkg;

  localparam int TS_CYCLE_WIDTH = 28;
  localparam int TS_PPS_WIDTH   = 16;
  localparam int TS_DROP_WIDTH  = 8;

  typedef struct packed {
    logic [TS_PPS_WIDTH-1:0]   pps;
    logic [TS_CYCLE_WIDTH-1:0] cycle;
  } ts_entry_t;

endpackage

// File: rtl/gray_to_bin_pipe.sv
// Two-stage Gray-to-binary converter with a valid bit and a sideband word
// carried alongside, so the pair leaves the pipe coherent.
module gray_to_bin_pipe #(
  parameter int WIDTH      = 28,
  parameter int SIDE_WIDTH = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic                  valid_i,
  input  logic [WIDTH-1:0]      gray_i,
  input  logic [SIDE_WIDTH-1:0] side_i,
  output logic                  valid_o,
  output logic [WIDTH-1:0]      bin_o,
  output logic [SIDE_WIDTH-1:0] side_o
);

  localparam int LO_W = WIDTH / 2;

  logic                  s1_valid_d, s1_valid_q;
  logic [WIDTH-1:0]      s1_gray_d, s1_gray_q;
  logic [SIDE_WIDTH-1:0] s1_side_d, s1_side_q;
  logic                  s2_valid_d, s2_valid_q;
  logic [WIDTH-1:0]      s2_mix_d, s2_mix_q;
  logic [SIDE_WIDTH-1:0] s2_side_d, s2_side_q;
  logic [WIDTH-1:0]      bin_s;

  // s2_mix holds the upper half already in binary and the lower half still in Gray
  always_comb begin
    s1_valid_d = valid_i;
    s2_valid_d = s1_valid_q;
    if (valid_i) begin
      s1_gray_d = gray_i;
      s1_side_d = side_i;
    end else begin
      s1_gray_d = s1_gray_q;
      s1_side_d = s1_side_q;
    end
    s2_mix_d = s1_gray_q;
    for (int i = WIDTH - 2; i >= LO_W; i--) begin
      s2_mix_d[i] = s2_mix_d[i+1] ^ s1_gray_q[i];
    end
    if (s1_valid_q) begin
      s2_side_d = s1_side_q;
    end else begin
      s2_side_d = s2_side_q;
      s2_mix_d  = s2_mix_q;
    end
    bin_s = s2_mix_q;
    for (int i = LO_W - 1; i >= 0; i--) begin
      bin_s[i] = bin_s[i+1] ^ s2_mix_q[i];
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      s1_valid_q <= 1'b0;
      s1_gray_q  <= {WIDTH{1'b0}};
      s1_side_q  <= {SIDE_WIDTH{1'b0}};
      s2_valid_q <= 1'b0;
      s2_mix_q   <= {WIDTH{1'b0}};
      s2_side_q  <= {SIDE_WIDTH{1'b0}};
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_gray_q  <= s1_gray_d;
      s1_side_q  <= s1_side_d;
      s2_valid_q <= s2_valid_d;
      s2_mix_q   <= s2_mix_d;
      s2_side_q  <= s2_side_d;
    end
  end

  assign valid_o = s2_valid_q;
  assign bin_o   = bin_s;
  assign side_o  = s2_side_q;

endmodule

// File: rtl/event_timestamp_fifo.sv
// Captures {pps, cycle} on each event, converts the Gray cycle count and
// queues the timestamp in a show-ahead FIFO with drop tracking.
module event_timestamp_fifo
  import ts_pkg::*;
#(
  parameter int DEPTH       = 4,
  parameter int CYCLE_WIDTH = TS_CYCLE_WIDTH,
  parameter int PPS_WIDTH   = TS_PPS_WIDTH
) (
  input  logic                         clk_i,
  input  logic                         rst_n_i,
  input  logic [CYCLE_WIDTH-1:0]       cycle_count_gray_i,
  input  logic [PPS_WIDTH-1:0]         pps_count_i,
  input  logic                         event_i,
  input  logic                         rd_i,
  input  logic                         overflow_clr_i,
  output logic                         valid_o,
  output logic [CYCLE_WIDTH-1:0]       ts_cycle_o,
  output logic [PPS_WIDTH-1:0]         ts_pps_o,
  output logic [$clog2(DEPTH+1)-1:0]   count_o,
  output logic                         overflow_o,
  output logic [TS_DROP_WIDTH-1:0]     drop_count_o
);

  localparam int PTR_W   = $clog2(DEPTH);
  localparam int CNT_W   = $clog2(DEPTH + 1);
  localparam int ENTRY_W = PPS_WIDTH + CYCLE_WIDTH;

  logic                     wr_valid_s;
  logic [CYCLE_WIDTH-1:0]   wr_cycle_s;
  logic [PPS_WIDTH-1:0]     wr_pps_s;
  logic [ENTRY_W-1:0]       wdata_s;
  logic                     full_s, pop_s, push_s, drop_s;

  logic [ENTRY_W-1:0]       mem_d [DEPTH];
  logic [ENTRY_W-1:0]       mem_q [DEPTH];
  logic [PTR_W-1:0]         wr_ptr_d, wr_ptr_q, rd_ptr_d, rd_ptr_q;
  logic [CNT_W-1:0]         count_d, count_q;
  logic                     valid_d, valid_q;
  logic [ENTRY_W-1:0]       head_d, head_q;
  logic                     ovf_d, ovf_q;
  logic [TS_DROP_WIDTH-1:0] drop_cnt_d, drop_cnt_q;

  gray_to_bin_pipe #(
    .WIDTH      (CYCLE_WIDTH),
    .SIDE_WIDTH (PPS_WIDTH)
  ) u_g2b (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .valid_i (event_i),
    .gray_i  (cycle_count_gray_i),
    .side_i  (pps_count_i),
    .valid_o (wr_valid_s),
    .bin_o   (wr_cycle_s),
    .side_o  (wr_pps_s)
  );

  assign wdata_s = {wr_pps_s, wr_cycle_s};

  // A pop frees the slot in time for a write arriving at a full FIFO
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    full_s   = (count_q == CNT_W'(DEPTH));
    pop_s    = rd_i && (count_q != {CNT_W{1'b0}});
    push_s   = wr_valid_s && (!full_s || pop_s);
    drop_s   = wr_valid_s && full_s && !pop_s;
    if (push_s) begin
      mem_d[wr_ptr_q] = wdata_s;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_s) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({push_s, pop_s})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
    valid_d = (count_d != {CNT_W{1'b0}});
    // New head may be the entry being written this very edge
    if (!valid_d) begin
      head_d = head_q;
    end else if (push_s && (wr_ptr_q == rd_ptr_d)) begin
      head_d = wdata_s;
    end else begin
      head_d = mem_q[rd_ptr_d];
    end
    if (drop_s) begin
      ovf_d = 1'b1;
      if (overflow_clr_i) begin
        drop_cnt_d = TS_DROP_WIDTH'(1);
      end else if (drop_cnt_q == {TS_DROP_WIDTH{1'b1}}) begin
        drop_cnt_d = drop_cnt_q;
      end else begin
        drop_cnt_d = drop_cnt_q + TS_DROP_WIDTH'(1);
      end
    end else if (overflow_clr_i) begin
      ovf_d      = 1'b0;
      drop_cnt_d = {TS_DROP_WIDTH{1'b0}};
    end else begin
      ovf_d      = ovf_q;
      drop_cnt_d = drop_cnt_q;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= {ENTRY_W{1'b0}};
      end
      wr_ptr_q   <= {PTR_W{1'b0}};
      rd_ptr_q   <= {PTR_W{1'b0}};
      count_q    <= {CNT_W{1'b0}};
      valid_q    <= 1'b0;
      head_q     <= {ENTRY_W{1'b0}};
      ovf_q      <= 1'b0;
      drop_cnt_q <= {TS_DROP_WIDTH{1'b0}};
    end else begin
      mem_q      <= mem_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      valid_q    <= valid_d;
      head_q     <= head_d;
      ovf_q      <= ovf_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  assign valid_o      = valid_q;
  assign count_o      = count_q;
  assign ts_cycle_o   = head_q[CYCLE_WIDTH-1:0];
  assign ts_pps_o     = head_q[ENTRY_W-1:CYCLE_WIDTH];
  assign overflow_o   = ovf_q;
  assign drop_count_o = drop_cnt_q;

endmodule

// File: tb/tb_event_timestamp_fifo.sv
// Directed bench for event_timestamp_fifo: capture latency, PPS coherence,
// overflow/saturation, write-stage pop, and asynchronous reset.
module tb_event_timestamp_fifo;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [27:0] gray = 28'd0;
  logic [15:0] pps = 16'd0;
  logic        evt = 1'b0;
  logic        rd = 1'b0;
  logic        clr = 1'b0;
  logic        valid;
  logic [27:0] ts_cycle;
  logic [15:0] ts_pps;
  logic [2:0]  count;
  logic        ovf;
  logic [7:0]  drops;

  int compared = 0;
  int mismatched = 0;

  event_timestamp_fifo #(.DEPTH(4), .CYCLE_WIDTH(28), .PPS_WIDTH(16)) dut (
    .clk_i              (clk),
    .rst_n_i            (rst_n),
    .cycle_count_gray_i (gray),
    .pps_count_i        (pps),
    .event_i            (evt),
    .rd_i               (rd),
    .overflow_clr_i     (clr),
    .valid_o            (valid),
    .ts_cycle_o         (ts_cycle),
    .ts_pps_o           (ts_pps),
    .count_o            (count),
    .overflow_o         (ovf),
    .drop_count_o       (drops)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    if (obs !== exp) begin
      mismatched++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [27:0] to_gray(input logic [27:0] b);
    return b ^ (b >> 1);
  endfunction

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic pop();
    rd = 1'b1;
    step();
    rd = 1'b0;
  endtask

  task automatic check_head(input string tag, input logic [27:0] cyc, input logic [15:0] p);
    check_eq({tag, "_valid"}, 32'(valid), 32'd1);
    check_eq({tag, "_cycle"}, 32'(ts_cycle), 32'(cyc));
    check_eq({tag, "_pps"}, 32'(ts_pps), 32'(p));
  endtask

  initial begin
    #23;
    check_eq("rst_valid", 32'(valid), 32'd0);
    check_eq("rst_count", 32'(count), 32'd0);
    check_eq("rst_ovf", 32'(ovf), 32'd0);
    check_eq("rst_drops", 32'(drops), 32'd0);
    check_eq("rst_cycle", 32'(ts_cycle), 32'd0);
    check_eq("rst_pps", 32'(ts_pps), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    step();

    // Basic capture latency: edge N sample, write at edge N+2
    gray = 28'h000002D; pps = 16'h0005; evt = 1'b1;
    step();
    evt = 1'b0; gray = 28'h0000123; pps = 16'h0006;
    check_eq("lat_n0", 32'(valid), 32'd0);
    step();
    check_eq("lat_n1", 32'(valid), 32'd0);
    step();
    check_head("first", 28'h0000036, 16'h0005);
    check_eq("first_count", 32'(count), 32'd1);
    pop();
    check_eq("pop_valid", 32'(valid), 32'd0);
    check_eq("pop_hold", 32'(ts_cycle), 32'h36);
    pop();
    check_eq("empty_rd_count", 32'(count), 32'd0);
    check_eq("empty_rd_valid", 32'(valid), 32'd0);

    // Event on the last cycle of a second, then the first of the next
    gray = to_gray(28'd99999999); pps = 16'd7; evt = 1'b1;
    step();
    gray = 28'd0; pps = 16'd8;
    step();
    evt = 1'b0; gray = 28'd1; pps = 16'd8;
    step();
    check_head("pps_old", 28'd99999999, 16'd7);
    step();
    check_eq("pps_count", 32'(count), 32'd2);
    pop();
    check_head("pps_new", 28'd0, 16'd8);
    pop();
    check_eq("pps_empty", 32'(valid), 32'd0);

    // Six back-to-back events into a 4-deep FIFO
    for (int i = 0; i < 6; i++) begin
      gray = to_gray(28'(100 + i)); pps = 16'(10 + i); evt = 1'b1;
      step();
    end
    evt = 1'b0;
    step();
    step();
    step();
    check_eq("ovf6_count", 32'(count), 32'd4);
    check_eq("ovf6_ovf", 32'(ovf), 32'd1);
    check_eq("ovf6_drops", 32'(drops), 32'd2);
    for (int i = 0; i < 4; i++) begin
      check_head("order", 28'(100 + i), 16'(10 + i));
      pop();
    end
    check_eq("order_empty", 32'(valid), 32'd0);
    clr = 1'b1;
    step();
    clr = 1'b0;
    check_eq("clr1_ovf", 32'(ovf), 32'd0);

    // Full FIFO, pop coinciding with the write stage
    for (int i = 0; i < 4; i++) begin
      gray = to_gray(28'(200 + i)); pps = 16'd20; evt = 1'b1;
      step();
    end
    evt = 1'b0;
    step();
    step();
    check_eq("full_count", 32'(count), 32'd4);
    gray = to_gray(28'd300); pps = 16'd21; evt = 1'b1;
    step();
    evt = 1'b0;
    step();
    rd = 1'b1;
    step();
    rd = 1'b0;
    check_eq("swap_count", 32'(count), 32'd4);
    check_eq("swap_ovf", 32'(ovf), 32'd0);
    check_eq("swap_drops", 32'(drops), 32'd0);
    check_head("swap_h1", 28'd201, 16'd20);
    pop();
    pop();
    pop();
    check_head("swap_tail", 28'd300, 16'd21);
    pop();
    check_eq("swap_empty", 32'(valid), 32'd0);

    // Saturation: 304 events, 4 accepted, 300 dropped
    gray = to_gray(28'd500); pps = 16'd30; evt = 1'b1;
    for (int i = 0; i < 304; i++) step();
    evt = 1'b0;
    step();
    step();
    check_eq("sat_drops", 32'(drops), 32'd255);
    check_eq("sat_ovf", 32'(ovf), 32'd1);
    check_eq("sat_count", 32'(count), 32'd4);
    clr = 1'b1;
    step();
    clr = 1'b0;
    check_eq("clr_ovf", 32'(ovf), 32'd0);
    check_eq("clr_drops", 32'(drops), 32'd0);
    evt = 1'b1;
    step();
    evt = 1'b0;
    step();
    clr = 1'b1;
    step();
    clr = 1'b0;
    check_eq("clrdrop_ovf", 32'(ovf), 32'd1);
    check_eq("clrdrop_drops", 32'(drops), 32'd1);

    // Asynchronous reset with two entries held and one in flight
    pop();
    pop();
    check_eq("prerst_count", 32'(count), 32'd2);
    gray = to_gray(28'd777); pps = 16'd40; evt = 1'b1;
    step();
    evt = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("arst_valid", 32'(valid), 32'd0);
    check_eq("arst_count", 32'(count), 32'd0);
    check_eq("arst_ovf", 32'(ovf), 32'd0);
    check_eq("arst_drops", 32'(drops), 32'd0);
    check_eq("arst_cycle", 32'(ts_cycle), 32'd0);
    check_eq("arst_pps", 32'(ts_pps), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) step();
    check_eq("postrst_valid", 32'(valid), 32'd0);
    check_eq("postrst_count", 32'(count), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
